// File: rtl/fp16_adder.sv
// -----------------------------------------------------------------------------
// fp16_adder
//   Three-stage pipelined IEEE-754 binary16 adder for the neuron datapath.
//   One operand pair may be accepted per cycle. The sum appears on out_Out
//   together with a one-cycle out_Ready strobe after the third rising edge,
//   counting the capture edge. out_Out holds its last value while out_Ready=0.
//
//   Stage 1 (align)     : unpack, order by magnitude, align smaller significand
//                         with guard/round/sticky bits, resolve special cases.
//   Stage 2 (add)       : effective add or subtract of the aligned significands.
//   Stage 3 (normalize) : normalize, round, detect overflow/underflow, pack.
//
//   Subnormal operands are treated as signed zero; tiny results flush to +0.
//   Default rounding is truncation (toward zero). Define the macro
//   FP16_ADD_ROUND_NEAREST_EN to round to nearest, ties to even.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset
//   in_A      in  16   operand A (binary16)
//   in_B      in  16   operand B (binary16)
//   in_En     in   1   operand-valid strobe
//   out_Out   out 16   registered sum (binary16)
//   out_Ready out  1   registered result-valid strobe
// -----------------------------------------------------------------------------
module fp16_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_A,
    input  logic [15:0] in_B,
    input  logic        in_En,
    output logic [15:0] out_Out,
    output logic        out_Ready
);

    // Leading-zero count over a 14-bit vector (returns 14 for an all-zero input).
    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] n;
        logic       found;
        n     = 4'd0;
        found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

    // ---------------------------------------------------------------- unpack
    logic        a_sign_s, b_sign_s;
    logic [4:0]  a_exp_s, b_exp_s;
    logic [9:0]  a_frac_s, b_frac_s;
    logic        a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
    logic [10:0] a_sig_s, b_sig_s;
    logic [14:0] a_mag_s, b_mag_s;

    assign a_sign_s = in_A[15];
    assign b_sign_s = in_B[15];
    assign a_exp_s  = in_A[14:10];
    assign b_exp_s  = in_B[14:10];
    assign a_frac_s = in_A[9:0];
    assign b_frac_s = in_B[9:0];
    assign a_zero_s = (a_exp_s == 5'd0);
    assign b_zero_s = (b_exp_s == 5'd0);
    assign a_inf_s  = (a_exp_s == 5'd31) && (a_frac_s == 10'd0);
    assign b_inf_s  = (b_exp_s == 5'd31) && (b_frac_s == 10'd0);
    assign a_nan_s  = (a_exp_s == 5'd31) && (a_frac_s != 10'd0);
    assign b_nan_s  = (b_exp_s == 5'd31) && (b_frac_s != 10'd0);
    // Exponent 0 means zero here: no hidden bit and zero magnitude.
    assign a_sig_s  = a_zero_s ? 11'd0 : {1'b1, a_frac_s};
    assign b_sig_s  = b_zero_s ? 11'd0 : {1'b1, b_frac_s};
    assign a_mag_s  = a_zero_s ? 15'd0 : in_A[14:0];
    assign b_mag_s  = b_zero_s ? 15'd0 : in_B[14:0];

    // ---------------------------------------------------------------- stage 1
    logic        l_sign_s;
    logic [4:0]  l_exp_s, s_exp_s, diff_s;
    logic [10:0] l_sig_s, s_sig_s;
    logic [27:0] wide_s;
    logic [13:0] small_al_s;
    logic        spec_s;
    logic [15:0] spec_val_s;

    // Order operands by magnitude and align the smaller one ({sig, G, R, S}).
    always_comb begin
        l_sign_s   = a_sign_s;
        l_exp_s    = a_exp_s;
        l_sig_s    = a_sig_s;
        s_exp_s    = b_exp_s;
        s_sig_s    = b_sig_s;
        if (a_mag_s >= b_mag_s) begin
            l_sign_s = a_sign_s;
            l_exp_s  = a_exp_s;
            l_sig_s  = a_sig_s;
            s_exp_s  = b_exp_s;
            s_sig_s  = b_sig_s;
        end else begin
            l_sign_s = b_sign_s;
            l_exp_s  = b_exp_s;
            l_sig_s  = b_sig_s;
            s_exp_s  = a_exp_s;
            s_sig_s  = a_sig_s;
        end
        diff_s = l_exp_s - s_exp_s;
        wide_s = {s_sig_s, 17'd0} >> diff_s;
        // Shifts of 13 or more leave nothing but the sticky bit.
        if (diff_s >= 5'd13) begin
            small_al_s = {13'd0, |s_sig_s};
        end else begin
            small_al_s = {wide_s[27:15], |wide_s[14:0]};
        end
    end

    // Resolve results that bypass the arithmetic path.
    always_comb begin
        spec_s     = 1'b0;
        spec_val_s = 16'h0000;
        if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_sign_s != b_sign_s))) begin
            spec_s     = 1'b1;
            spec_val_s = 16'h7E00;
        end else if (a_inf_s) begin
            spec_s     = 1'b1;
            spec_val_s = {a_sign_s, 15'h7C00};
        end else if (b_inf_s) begin
            spec_s     = 1'b1;
            spec_val_s = {b_sign_s, 15'h7C00};
        end else if (a_zero_s && b_zero_s && a_sign_s && b_sign_s) begin
            spec_s     = 1'b1;
            spec_val_s = 16'h8000;
        end else begin
            spec_s     = 1'b0;
            spec_val_s = 16'h0000;
        end
    end

    logic        v1_r, sign1_r, sub1_r, spec1_r;
    logic [4:0]  exp1_r;
    logic [10:0] big1_r;
    logic [13:0] small1_r;
    logic [15:0] spec_val1_r;

    // Stage 1 pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r        <= 1'b0;
            sign1_r     <= 1'b0;
            sub1_r      <= 1'b0;
            spec1_r     <= 1'b0;
            exp1_r      <= 5'd0;
            big1_r      <= 11'd0;
            small1_r    <= 14'd0;
            spec_val1_r <= 16'h0000;
        end else begin
            v1_r        <= in_En;
            sign1_r     <= l_sign_s;
            sub1_r      <= a_sign_s ^ b_sign_s;
            spec1_r     <= spec_s;
            exp1_r      <= l_exp_s;
            big1_r      <= l_sig_s;
            small1_r    <= small_al_s;
            spec_val1_r <= spec_val_s;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic [14:0] sum_s;

    // Larger magnitude is always first, so the subtraction never goes negative.
    always_comb begin
        sum_s = 15'd0;
        if (sub1_r) begin
            sum_s = {1'b0, big1_r, 3'b000} - {1'b0, small1_r};
        end else begin
            sum_s = {1'b0, big1_r, 3'b000} + {1'b0, small1_r};
        end
    end

    logic        v2_r, sign2_r, spec2_r;
    logic [4:0]  exp2_r;
    logic [14:0] sum2_r;
    logic [15:0] spec_val2_r;

    // Stage 2 pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r        <= 1'b0;
            sign2_r     <= 1'b0;
            spec2_r     <= 1'b0;
            exp2_r      <= 5'd0;
            sum2_r      <= 15'd0;
            spec_val2_r <= 16'h0000;
        end else begin
            v2_r        <= v1_r;
            sign2_r     <= sign1_r;
            spec2_r     <= spec1_r;
            exp2_r      <= exp1_r;
            sum2_r      <= sum_s;
            spec_val2_r <= spec_val1_r;
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic [3:0]         lz_s;
    logic [13:0]        mant_s;
    logic signed [6:0]  exp_n_s;
    logic [9:0]         frac_s;
    logic [15:0]        res_s;
`ifdef FP16_ADD_ROUND_NEAREST_EN
    logic               round_up_s;
    logic [11:0]        rnd_s;
`else
    logic               unused_grs_s;
    assign unused_grs_s = ^{mant_s[13], mant_s[2:0]};
`endif

    // Normalize ({hidden, frac, G, R, S} in mant_s), round and pack.
    always_comb begin
        lz_s    = lzc14(sum2_r[13:0]);
        mant_s  = 14'd0;
        exp_n_s = 7'sd0;
        frac_s  = 10'd0;
        res_s   = 16'h0000;
        if (sum2_r[14]) begin
            // Carry out: shift right one, folding the dropped bit into sticky.
            mant_s  = {sum2_r[14:2], sum2_r[1] | sum2_r[0]};
            exp_n_s = $signed({2'b00, exp2_r}) + 7'sd1;
        end else begin
            mant_s  = sum2_r[13:0] << lz_s;
            exp_n_s = $signed({2'b00, exp2_r}) - $signed({3'b000, lz_s});
        end
`ifdef FP16_ADD_ROUND_NEAREST_EN
        round_up_s = mant_s[2] & (mant_s[1] | mant_s[0] | mant_s[3]);
        rnd_s      = {1'b0, mant_s[13:3]} + {11'd0, round_up_s};
        // A rounding carry means the significand became 10.000...: renormalize.
        if (rnd_s[11]) begin
            frac_s  = rnd_s[10:1];
            exp_n_s = exp_n_s + 7'sd1;
        end else begin
            frac_s  = rnd_s[9:0];
        end
`else
        frac_s = mant_s[12:3];
`endif
        if (spec2_r) begin
            res_s = spec_val2_r;
        end else if (sum2_r == 15'd0) begin
            res_s = 16'h0000;
        end else if (exp_n_s < 7'sd1) begin
            res_s = 16'h0000;
        end else if (exp_n_s > 7'sd30) begin
            res_s = {sign2_r, 15'h7C00};
        end else begin
            res_s = {sign2_r, exp_n_s[4:0], frac_s};
        end
    end

    // Output register: strobe follows the stage 2 valid, data holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_Out   <= 16'h0000;
            out_Ready <= 1'b0;
        end else begin
            out_Ready <= v2_r;
            if (v2_r) begin
                out_Out <= res_s;
            end else begin
                out_Out <= out_Out;
            end
        end
    end

endmodule

// File: tb/tb_fp16_adder.sv
module tb_fp16_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_A;
    logic [15:0] in_B;
    logic        in_En;
    logic [15:0] out_Out;
    logic        out_Ready;

    int checks   = 0;
    int failures = 0;

    fp16_adder dut (
        .clk      (clk),
        .rst      (rst),
        .in_A     (in_A),
        .in_B     (in_B),
        .in_En    (in_En),
        .out_Out  (out_Out),
        .out_Ready(out_Ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] exp_out, input logic exp_rdy);
        checks++;
        assert (out_Out === exp_out) else begin
            failures++;
            $error("FAIL %s out_Out observed=%h expected=%h", tag, out_Out, exp_out);
        end
        checks++;
        assert (out_Ready === exp_rdy) else begin
            failures++;
            $error("FAIL %s out_Ready observed=%b expected=%b", tag, out_Ready, exp_rdy);
        end
    endtask

    // Single isolated operation: drive, wait three edges, check, then check hold.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_sum);
        in_A  = a;
        in_B  = b;
        in_En = 1'b1;
        tick();
        in_En = 1'b0;
        tick();
        tick();
        check_out(tag, exp_sum, 1'b1);
        tick();
        check_out({tag, "_hold"}, exp_sum, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        in_A  = 16'h0000;
        in_B  = 16'h0000;
        in_En = 1'b0;
        tick();
        rst = 1'b0;
        check_out("reset", 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("idle_after_reset", 16'h0000, 1'b0);
        end

        // 400 + 3678 = 4078, with latency check
        in_A  = 16'h5E40;
        in_B  = 16'h6B2F;
        in_En = 1'b1;
        tick();
        in_En = 1'b0;
        tick();
        check_out("latency_early", 16'h0000, 1'b0);
        tick();
        check_out("sum_400_3678", 16'h6BF7, 1'b1);
        tick();
        check_out("sum_hold", 16'h6BF7, 1'b0);
        tick();
        check_out("sum_hold2", 16'h6BF7, 1'b0);

        // Back-to-back stream
        in_A = 16'h3C00; in_B = 16'h3C00; in_En = 1'b1;
        tick();
        in_A = 16'h3C00; in_B = 16'hBC00;
        tick();
        in_A = 16'h3C00; in_B = 16'h1400;
        tick();
        in_En = 1'b0;
        check_out("b2b_1p1", 16'h4000, 1'b1);
        tick();
        check_out("b2b_1m1", 16'h0000, 1'b1);
        tick();
        check_out("b2b_1pulp", 16'h3C01, 1'b1);
        tick();
        check_out("b2b_end", 16'h3C01, 1'b0);

        // Overflow and specials
        run_one("overflow", 16'h7BFF, 16'h7BFF, 16'h7C00);
        run_one("inf_minus_inf", 16'h7C00, 16'hFC00, 16'h7E00);
        run_one("nan_in", 16'h7E01, 16'h3C00, 16'h7E00);
        run_one("inf_plus_fin", 16'h7C00, 16'h3C00, 16'h7C00);
        run_one("fin_plus_ninf", 16'h4000, 16'hFC00, 16'hFC00);
        run_one("negzero", 16'h8000, 16'h8000, 16'h8000);
        run_one("mixzero", 16'h8000, 16'h0000, 16'h0000);
        run_one("subnormal_op", 16'h0001, 16'h3C00, 16'h3C00);
        run_one("underflow_flush", 16'h0401, 16'h8400, 16'h0000);
        run_one("neg_larger", 16'h3C00, 16'hC000, 16'hBC00);
        run_one("sub_exact", 16'h3C00, 16'h9000, 16'h3BFF);
        run_one("sub_sticky", 16'h3C00, 16'h8E00, 16'h3BFF);

        // Rounding (1 + 0.75 ulp)
`ifdef FP16_ADD_ROUND_NEAREST_EN
        run_one("round", 16'h3C00, 16'h1200, 16'h3C01);
`else
        run_one("round", 16'h3C00, 16'h1200, 16'h3C00);
`endif

        // Reset mid-flight: operation discarded, outputs cleared
        in_A  = 16'h3C00;
        in_B  = 16'h3C00;
        in_En = 1'b1;
        tick();
        in_En = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        check_out("midreset_0", 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("midreset_n", 16'h0000, 1'b0);
        end

        // rst wins over in_En at the same edge
        in_A  = 16'h4000;
        in_B  = 16'h4000;
        in_En = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        in_En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("rst_priority", 16'h0000, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
